// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: ALU forwarding selects and FSM state encoding.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      from_idex  = 2'd0,
      from_exmem = 2'd1,
      from_memwb = 2'd2
   } forward_t;

   typedef logic [1:0] pipe_ctrl_state_t;

   localparam pipe_ctrl_state_t RUN   = 2'd0;
   localparam pipe_ctrl_state_t DWAIT = 2'd1;
   localparam pipe_ctrl_state_t REDIR = 2'd2;

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Forwarding select for one EX ALU operand; purely combinational, zero latency, no flow control.
// EX/MEM is the younger producer, so it wins over MEM/WB.
module fwd_unit
   import pipeline_ctrl_pkg::*;
(
   input  logic       i_sel_is_rs,
   input  logic [4:0] i_ex_rs,
   input  logic [4:0] i_exmem_rd,
   input  logic       i_exmem_regwrite,
   input  logic [4:0] i_memwb_rd,
   input  logic       i_memwb_regwrite,
   output forward_t   o_fw
);

   logic w_hit_exmem;
   logic w_hit_memwb;

   assign w_hit_exmem = i_sel_is_rs & i_exmem_regwrite & (i_exmem_rd != 5'd0) & (i_exmem_rd == i_ex_rs);
   assign w_hit_memwb = i_sel_is_rs & i_memwb_regwrite & (i_memwb_rd != 5'd0) & (i_memwb_rd == i_ex_rs);

   always_comb begin
      o_fw = from_idex;
      if (w_hit_exmem)
         o_fw = from_exmem;
      else if (w_hit_memwb)
         o_fw = from_memwb;
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller for the 5-stage rv32i pipeline: stage enables, bubbles, redirect and forwarding.
// Outputs are combinational from current state; redirect target and perf counters are registered.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             idex_valid,
   input  logic             idex_load,
   input  logic [4:0]       idex_rd,
   input  logic [4:0]       ex_rs1,
   input  logic [4:0]       ex_rs2,
   input  logic             ex_a_is_rs1,
   input  logic             ex_b_is_rs2,
   input  logic [4:0]       exmem_rd,
   input  logic [4:0]       memwb_rd,
   input  logic             exmem_regwrite,
   input  logic             memwb_regwrite,
   input  logic             ex_valid,
   input  logic             ex_correct_pc_prediction,
   input  logic [31:0]      ex_next_pc,
   input  logic             imem_busy,
   input  logic             imem_resp,
   input  logic             dmem_busy,
   input  logic             dmem_resp,
   output logic             load_pc,
   output logic             load_ifid,
   output logic             load_idex,
   output logic             load_exmem,
   output logic             load_memwb,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output forward_t         alumux1_fw,
   output forward_t         alumux2_fw,
   output logic [CNT_W-1:0] perf_stall_cnt,
   output logic [CNT_W-1:0] perf_mispredict_cnt
);

   pipe_ctrl_state_t r_state;
   pipe_ctrl_state_t w_state_nxt;
   logic [31:0]      r_redirect_pc;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_misp_cnt;

   logic w_dwait, w_misp, w_load_use, w_imem_wait;
   logic w_load_pc, w_load_ifid, w_load_idex, w_load_exmem, w_load_memwb;
   logic w_flush_ifid, w_flush_idex, w_redirect, w_rpc_live, w_misp_act;
   forward_t w_fw1, w_fw2;

   fwd_unit u_fwd_a (
      .i_sel_is_rs      (ex_a_is_rs1),
      .i_ex_rs          (ex_rs1),
      .i_exmem_rd       (exmem_rd),
      .i_exmem_regwrite (exmem_regwrite),
      .i_memwb_rd       (memwb_rd),
      .i_memwb_regwrite (memwb_regwrite),
      .o_fw             (w_fw1)
   );

   fwd_unit u_fwd_b (
      .i_sel_is_rs      (ex_b_is_rs2),
      .i_ex_rs          (ex_rs2),
      .i_exmem_rd       (exmem_rd),
      .i_exmem_regwrite (exmem_regwrite),
      .i_memwb_rd       (memwb_rd),
      .i_memwb_regwrite (memwb_regwrite),
      .o_fw             (w_fw2)
   );

   // Once in DWAIT only dmem_resp releases the freeze, regardless of dmem_busy.
   assign w_dwait     = (r_state == DWAIT) ? !dmem_resp : (dmem_busy & !dmem_resp);
   assign w_misp      = ex_valid & !ex_correct_pc_prediction;
   assign w_load_use  = idex_valid & idex_load & (idex_rd != 5'd0) &
                        ((idex_rd == id_rs1) | (idex_rd == id_rs2));
   assign w_imem_wait = imem_busy & !imem_resp;

   always_comb begin
      w_state_nxt  = r_state;
      w_load_pc    = 1'b0;
      w_load_ifid  = 1'b0;
      w_load_idex  = 1'b0;
      w_load_exmem = 1'b0;
      w_load_memwb = 1'b0;
      w_flush_ifid = 1'b0;
      w_flush_idex = 1'b0;
      w_redirect   = 1'b0;
      w_rpc_live   = 1'b0;
      w_misp_act   = 1'b0;
      if (w_dwait) begin
         if (r_state == RUN)
            w_state_nxt = DWAIT;
      end else if (r_state == REDIR) begin
         w_load_ifid  = 1'b1;
         w_load_idex  = 1'b1;
         w_load_exmem = 1'b1;
         w_load_memwb = 1'b1;
         w_flush_ifid = 1'b1;
         if (imem_resp) begin
            w_load_pc   = 1'b1;
            w_redirect  = 1'b1;
            w_state_nxt = RUN;
         end
      end else begin
         w_state_nxt  = RUN;
         w_load_exmem = 1'b1;
         w_load_memwb = 1'b1;
         w_load_idex  = 1'b1;
         if (w_misp) begin
            w_misp_act   = 1'b1;
            w_load_ifid  = 1'b1;
            w_flush_ifid = 1'b1;
            w_flush_idex = 1'b1;
            if (!w_imem_wait) begin
               w_load_pc  = 1'b1;
               w_redirect = 1'b1;
               w_rpc_live = 1'b1;
            end else begin
               w_state_nxt = REDIR;
            end
         end else if (w_load_use) begin
            w_flush_idex = 1'b1;
         end else if (w_imem_wait) begin
            w_load_ifid  = 1'b1;
            w_flush_ifid = 1'b1;
         end else begin
            w_load_pc   = 1'b1;
            w_load_ifid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= RUN;
         r_redirect_pc <= 32'd0;
         r_stall_cnt   <= '0;
         r_misp_cnt    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_misp_act)
            r_redirect_pc <= ex_next_pc;
         if (!w_load_pc && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_misp_act && (r_misp_cnt != '1))
            r_misp_cnt <= r_misp_cnt + CNT_W'(1);
      end
   end

   assign load_pc             = !rst & w_load_pc;
   assign load_ifid           = !rst & w_load_ifid;
   assign load_idex           = !rst & w_load_idex;
   assign load_exmem          = !rst & w_load_exmem;
   assign load_memwb          = !rst & w_load_memwb;
   assign flush_ifid          = !rst & w_flush_ifid;
   assign flush_idex          = !rst & w_flush_idex;
   assign redirect_valid      = !rst & w_redirect;
   assign redirect_pc         = (w_rpc_live & !rst) ? ex_next_pc : r_redirect_pc;
   assign alumux1_fw          = rst ? from_idex : w_fw1;
   assign alumux2_fw          = rst ? from_idex : w_fw2;
   assign perf_stall_cnt      = r_stall_cnt;
   assign perf_mispredict_cnt = r_misp_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expectations queued at drive time, popped at each sample point.
module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic [4:0] id_rs1, id_rs2, idex_rd, ex_rs1, ex_rs2, exmem_rd, memwb_rd;
   logic idex_valid, idex_load, ex_a_is_rs1, ex_b_is_rs2, exmem_regwrite, memwb_regwrite;
   logic ex_valid, ex_correct_pc_prediction, imem_busy, imem_resp, dmem_busy, dmem_resp;
   logic [31:0] ex_next_pc;
   logic load_pc, load_ifid, load_idex, load_exmem, load_memwb, flush_ifid, flush_idex, redirect_valid;
   logic [31:0] redirect_pc;
   forward_t alumux1_fw, alumux2_fw;
   logic [31:0] perf_stall_cnt, perf_mispredict_cnt;

   wire [4:0] w_loads = {load_pc, load_ifid, load_idex, load_exmem, load_memwb};
   wire [1:0] w_flush = {flush_ifid, flush_idex};

   int n_asserts = 0;
   int n_fails   = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   pipeline_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .idex_valid(idex_valid), .idex_load(idex_load), .idex_rd(idex_rd),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_a_is_rs1(ex_a_is_rs1), .ex_b_is_rs2(ex_b_is_rs2),
      .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_regwrite(exmem_regwrite),
      .memwb_regwrite(memwb_regwrite), .ex_valid(ex_valid),
      .ex_correct_pc_prediction(ex_correct_pc_prediction), .ex_next_pc(ex_next_pc),
      .imem_busy(imem_busy), .imem_resp(imem_resp), .dmem_busy(dmem_busy), .dmem_resp(dmem_resp),
      .load_pc(load_pc), .load_ifid(load_ifid), .load_idex(load_idex), .load_exmem(load_exmem),
      .load_memwb(load_memwb), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .alumux1_fw(alumux1_fw), .alumux2_fw(alumux2_fw),
      .perf_stall_cnt(perf_stall_cnt), .perf_mispredict_cnt(perf_mispredict_cnt)
   );

   task automatic push(input string t, input logic [31:0] v);
      tag_q.push_back(t);
      exp_q.push_back(v);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      logic [31:0] e;
      string t;
      n_asserts++;
      if (exp_q.size() == 0) begin
         n_fails++;
         $error("FAIL scoreboard_empty observed=0x%0h", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", t, obs, e);
         end
      end
   endtask

   task automatic chk_now(input string t, input logic [31:0] obs, input logic [31:0] e);
      push(t, e);
      pop_chk(obs);
   endtask

   // One full cycle: queue expectations, sample mid-cycle, advance to 1ns after the next edge.
   task automatic cyc(input string t, input logic [4:0] le, input logic [1:0] fe,
                      input logic rve, input logic [31:0] rpce);
      push({t, ".loads"}, {27'd0, le});
      push({t, ".flush"}, {30'd0, fe});
      push({t, ".redirect_valid"}, {31'd0, rve});
      push({t, ".redirect_pc"}, rpce);
      #2;
      pop_chk({27'd0, w_loads});
      pop_chk({30'd0, w_flush});
      pop_chk({31'd0, redirect_valid});
      pop_chk(redirect_pc);
      @(posedge clk);
      #1;
   endtask

   task automatic defaults();
      id_rs1 = 5'd1;  id_rs2 = 5'd2;  idex_valid = 1'b1; idex_load = 1'b0; idex_rd = 5'd10;
      ex_rs1 = 5'd11; ex_rs2 = 5'd12; ex_a_is_rs1 = 1'b1; ex_b_is_rs2 = 1'b1;
      exmem_rd = 5'd13; memwb_rd = 5'd14; exmem_regwrite = 1'b1; memwb_regwrite = 1'b1;
      ex_valid = 1'b1; ex_correct_pc_prediction = 1'b1; ex_next_pc = 32'd0;
      imem_busy = 1'b0; imem_resp = 1'b0; dmem_busy = 1'b0; dmem_resp = 1'b0;
   endtask

   initial begin
      defaults();
      rst = 1'b1;
      ex_rs1 = 5'd13;
      ex_correct_pc_prediction = 1'b0;
      ex_next_pc = 32'h44;
      #2;
      chk_now("rst.loads", {27'd0, w_loads}, 32'd0);
      chk_now("rst.flush", {30'd0, w_flush}, 32'd0);
      chk_now("rst.redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk_now("rst.redirect_pc", redirect_pc, 32'd0);
      chk_now("rst.fw1", {30'd0, alumux1_fw}, 32'd0);
      chk_now("rst.stall_cnt", perf_stall_cnt, 32'd0);
      chk_now("rst.misp_cnt", perf_mispredict_cnt, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      defaults();
      cyc("idle", 5'b11111, 2'b00, 1'b0, 32'd0);

      // Forwarding selects
      ex_rs1 = 5'd5; exmem_rd = 5'd5; memwb_rd = 5'd5; ex_rs2 = 5'd5;
      #1 chk_now("fw1.exmem", {30'd0, alumux1_fw}, 32'd1);
      chk_now("fw2.exmem", {30'd0, alumux2_fw}, 32'd1);
      exmem_rd = 5'd0;
      #1 chk_now("fw1.memwb", {30'd0, alumux1_fw}, 32'd2);
      chk_now("fw2.memwb", {30'd0, alumux2_fw}, 32'd2);
      ex_b_is_rs2 = 1'b0;
      #1 chk_now("fw2.not_rs", {30'd0, alumux2_fw}, 32'd0);
      memwb_regwrite = 1'b0;
      #1 chk_now("fw1.no_wr", {30'd0, alumux1_fw}, 32'd0);
      @(posedge clk);
      #1;
      defaults();

      // Load-use stall, then the bubble clears it
      idex_load = 1'b1; idex_rd = 5'd3; id_rs2 = 5'd3;
      cyc("lduse", 5'b00111, 2'b01, 1'b0, 32'd0);
      idex_valid = 1'b0;
      cyc("lduse_after", 5'b11111, 2'b00, 1'b0, 32'd0);
      chk_now("lduse.stall_cnt", perf_stall_cnt, 32'd1);
      idex_valid = 1'b1; idex_rd = 5'd0; id_rs1 = 5'd0;
      cyc("lduse_x0", 5'b11111, 2'b00, 1'b0, 32'd0);
      defaults();

      // Dcache wait with a mispredict parked in EX
      dmem_busy = 1'b1; ex_correct_pc_prediction = 1'b0; ex_next_pc = 32'h80;
      for (int i = 0; i < 4; i++) begin
         cyc("dwait", 5'b00000, 2'b00, 1'b0, 32'd0);
         chk_now("dwait.state", {30'd0, dut.r_state}, 32'd1);
      end
      dmem_busy = 1'b0; dmem_resp = 1'b1;
      cyc("dresp", 5'b11111, 2'b11, 1'b1, 32'h80);
      chk_now("dresp.state", {30'd0, dut.r_state}, 32'd0);
      chk_now("dresp.misp_cnt", perf_mispredict_cnt, 32'd1);
      chk_now("dresp.stall_cnt", perf_stall_cnt, 32'd5);
      defaults();

      imem_busy = 1'b1;
      cyc("iwait", 5'b01111, 2'b10, 1'b0, 32'h80);
      chk_now("iwait.stall_cnt", perf_stall_cnt, 32'd6);
      defaults();

      // Mispredict with idle icache: same-cycle redirect
      ex_correct_pc_prediction = 1'b0; ex_next_pc = 32'h60;
      cyc("misp_idle", 5'b11111, 2'b11, 1'b0 | 1'b1, 32'h60);
      chk_now("misp_idle.cnt", perf_mispredict_cnt, 32'd2);
      defaults();

      // Mispredict during icache fetch: held in REDIR until imem_resp
      imem_busy = 1'b1; ex_correct_pc_prediction = 1'b0; ex_next_pc = 32'h60;
      cyc("misp_busy", 5'b01111, 2'b11, 1'b0, 32'h60);
      chk_now("misp_busy.state", {30'd0, dut.r_state}, 32'd2);
      chk_now("misp_busy.cnt", perf_mispredict_cnt, 32'd3);
      ex_valid = 1'b0; ex_correct_pc_prediction = 1'b1; ex_next_pc = 32'h1234;
      cyc("redir1", 5'b01111, 2'b10, 1'b0, 32'h60);
      cyc("redir2", 5'b01111, 2'b10, 1'b0, 32'h60);
      chk_now("redir2.state", {30'd0, dut.r_state}, 32'd2);
      imem_resp = 1'b1;
      cyc("redir_resp", 5'b11111, 2'b10, 1'b1, 32'h60);
      chk_now("redir_resp.state", {30'd0, dut.r_state}, 32'd0);
      chk_now("redir_resp.stall_cnt", perf_stall_cnt, 32'd9);
      defaults();

      // REDIR frozen by a dcache wait, then reset lands mid-REDIR
      imem_busy = 1'b1; ex_correct_pc_prediction = 1'b0; ex_next_pc = 32'h70;
      cyc("misp_busy2", 5'b01111, 2'b11, 1'b0, 32'h60);
      ex_valid = 1'b0; ex_correct_pc_prediction = 1'b1; dmem_busy = 1'b1;
      cyc("redir_dwait", 5'b00000, 2'b00, 1'b0, 32'h70);
      chk_now("redir_dwait.state", {30'd0, dut.r_state}, 32'd2);
      chk_now("redir_dwait.stall_cnt", perf_stall_cnt, 32'd11);
      chk_now("redir_dwait.misp_cnt", perf_mispredict_cnt, 32'd4);
      dmem_busy = 1'b0; imem_resp = 1'b1;
      #1 chk_now("pre_rst.redirect_valid", {31'd0, redirect_valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk_now("async_rst.redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk_now("async_rst.loads", {27'd0, w_loads}, 32'd0);
      chk_now("async_rst.state", {30'd0, dut.r_state}, 32'd0);
      chk_now("async_rst.stall_cnt", perf_stall_cnt, 32'd0);
      chk_now("async_rst.misp_cnt", perf_mispredict_cnt, 32'd0);
      chk_now("async_rst.redirect_pc", redirect_pc, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      defaults();
      cyc("post_rst", 5'b11111, 2'b00, 1'b0, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
